// File: rtl/fir_interp_polyphase.sv
// Polyphase FIR interpolator: upsamples a low-rate stream by M through an ORD+1-tap symmetric
// low-pass filter using one multiply-accumulate per clock, emitting one output every D clocks.
module fir_interp_polyphase #(
  parameter int ORD         = 255,
  parameter int M           = 8,
  parameter int D           = 100,
  parameter int COEFF_SIZE  = 16,
  parameter int SAMPLE_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [2:0]             div,
  input  logic [SAMPLE_SIZE-1:0] din,
  output logic [SAMPLE_SIZE-1:0] dout,
  input  logic                   c_we,
  input  logic [COEFF_SIZE-1:0]  c_in,
  input  logic [7:0]             c_addr
);

  localparam int TAPS   = (ORD + 1) / M;
  localparam int HALF   = (ORD + 1) / 2;
  localparam int CW     = $clog2(D);
  localparam int PW     = (M > 1) ? $clog2(M) : 1;
  localparam int TW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int KW     = $clog2(ORD + 1);
  localparam int HW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PROD_W = COEFF_SIZE + SAMPLE_SIZE;
  localparam int ACC_W  = PROD_W + $clog2(TAPS) + 1;
  localparam int SCL_W  = ACC_W + PW + 2;

  localparam logic signed [SCL_W-1:0] SAT_MAX = SCL_W'((longint'(1) <<< (SAMPLE_SIZE - 1)) - 1);
  localparam logic signed [SCL_W-1:0] SAT_MIN = -SAT_MAX - SCL_W'(1);

  // Slot timing
  logic [CW-1:0] cyc_q, cyc_d;
  logic [PW-1:0] ph_q, ph_d;
  logic          running, slot_start, frame_start, issue, slot_end;

  // Datapath
  logic [TAPS-1:0][SAMPLE_SIZE-1:0] x_q;
  logic signed [COEFF_SIZE-1:0]     ram [HALF];
  logic signed [COEFF_SIZE-1:0]     coef_q;
  logic signed [SAMPLE_SIZE-1:0]    xs_q;
  logic signed [PROD_W-1:0]         prod_q;
  logic signed [ACC_W-1:0]          acc_q;
  logic                             v1_q, v2_q;
  logic [SAMPLE_SIZE-1:0]           dout_q;

  logic [TW-1:0] tap_idx;
  logic [KW-1:0] k_idx;
  logic [HW-1:0] raddr;

  logic [5:0]              sh;
  logic signed [SCL_W-1:0] scaled, shifted, rounded;
  logic [SAMPLE_SIZE-1:0]  sat_val;

  assign running     = ~c_we;
  assign slot_start  = running && (cyc_q == '0);
  assign frame_start = slot_start && (ph_q == '0);
  assign slot_end    = running && (cyc_q == CW'(D - 1));
  // Tap j of the current phase is fetched in slot cycle j+1, after the delay line has shifted.
  assign issue       = running && (cyc_q >= CW'(1)) && (cyc_q <= CW'(TAPS));
  assign tap_idx     = TW'(cyc_q - CW'(1));

  // Only half the symmetric response is stored; the upper half folds back onto it.
  assign k_idx = KW'(tap_idx) * KW'(M) + KW'(ph_q);
  assign raddr = (k_idx < KW'(HALF)) ? HW'(k_idx) : HW'(KW'(ORD) - k_idx);

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch can form.
  always_comb begin
    cyc_d = cyc_q;
    ph_d  = ph_q;
    if (!running) begin
      cyc_d = '0;
      ph_d  = '0;
    end else if (cyc_q == CW'(D - 1)) begin
      cyc_d = '0;
      ph_d  = (ph_q == PW'(M - 1)) ? '0 : ph_q + PW'(1);
    end else begin
      cyc_d = cyc_q + CW'(1);
    end
  end

  // Round half up of y*M / 2^(COEFF_SIZE+div), then clamp to the sample range.
  always_comb begin
    sh      = 6'(COEFF_SIZE - 1) + 6'(div);
    scaled  = SCL_W'(acc_q) * SCL_W'(M);
    shifted = scaled >>> sh;
    rounded = (shifted + SCL_W'(1)) >>> 1;
    sat_val = rounded[SAMPLE_SIZE-1:0];
    if (rounded > SAT_MAX) begin
      sat_val = SAT_MAX[SAMPLE_SIZE-1:0];
    end else if (rounded < SAT_MIN) begin
      sat_val = SAT_MIN[SAMPLE_SIZE-1:0];
    end
  end

  // NOTE: the coefficient RAM and MAC operand registers have no reset, so the RAM can map onto block memory and keeps its contents across nrst.
  always_ff @(posedge clk) begin
    if (c_we && ({1'b0, c_addr} < 9'(HALF))) begin
      ram[c_addr[HW-1:0]] <= c_in;
    end
    if (issue) begin
      coef_q <= ram[raddr];
      xs_q   <= $signed(x_q[tap_idx]);
    end
    prod_q <= PROD_W'(coef_q) * PROD_W'(xs_q);
  end

  // NOTE: clocked state uses non-blocking '<=' only; reset is synchronous, tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cyc_q  <= '0;
      ph_q   <= '0;
      x_q    <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ph_q  <= ph_d;
      v1_q  <= issue;
      v2_q  <= v1_q & running;
      if (frame_start) begin
        x_q <= {x_q[TAPS-2:0], din};
      end
      if (slot_start) begin
        acc_q <= '0;
      end else if (v2_q && running) begin
        acc_q <= acc_q + ACC_W'(prod_q);
      end
      if (slot_end) begin
        dout_q <= sat_val;
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_fir_interp_polyphase.sv
// Self-checking bench for fir_interp_polyphase: a frame-level arithmetic model checked every cycle,
// plus directed impulse, zero, freeze, reset, rounding and saturation vectors with literal results.
module tb_fir_interp_polyphase;

  localparam int ORD  = 255;
  localparam int M    = 8;
  localparam int D    = 40;
  localparam int CS   = 16;
  localparam int SS   = 16;
  localparam int TAPS = (ORD + 1) / M;
  localparam int HALF = (ORD + 1) / 2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        c_we;
  logic [2:0]  div;
  logic [15:0] din;
  logic [15:0] dout;
  logic [15:0] c_in;
  logic [7:0]  c_addr;

  fir_interp_polyphase #(
    .ORD(ORD), .M(M), .D(D), .COEFF_SIZE(CS), .SAMPLE_SIZE(SS)
  ) dut (
    .clk(clk), .nrst(nrst), .div(div), .din(din), .dout(dout),
    .c_we(c_we), .c_in(c_in), .c_addr(c_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: dout=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: stored half-response, sample history, time within the current frame.
  int          cm [HALF];
  int          xh [TAPS];
  int          t;
  logic [15:0] exp_dout;

  function automatic logic [15:0] model_out(input int p, input int dv);
    longint y;
    longint r;
    int     k;
    int     hk;
    y = 0;
    for (int j = 0; j < TAPS; j++) begin
      k  = j * M + p;
      hk = (k < HALF) ? cm[k] : cm[ORD - k];
      y += longint'(hk) * longint'(xh[j]);
    end
    r = (y * M + (longint'(1) <<< (CS + dv - 1))) >>> (CS + dv);
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  always @(posedge clk) begin
    if (c_we && c_addr < 8'(HALF)) cm[c_addr[6:0]] <= int'($signed(c_in));
    if (!nrst) begin
      t        <= 0;
      exp_dout <= 16'h0000;
      for (int j = 0; j < TAPS; j++) xh[j] <= 0;
    end else if (c_we) begin
      t <= 0;
    end else begin
      if (t == 0) begin
        for (int j = TAPS - 1; j > 0; j--) xh[j] <= xh[j-1];
        xh[0] <= int'($signed(din));
      end
      if (t % D == D - 1) exp_dout <= model_out(t / D, int'(div));
      t <= (t == M * D - 1) ? 0 : t + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) check("stream", dout, exp_dout);
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_coeffs(input bit sat);
    c_we = 1'b1;
    for (int a = 0; a < HALF; a++) begin
      c_addr = 8'(a);
      c_in   = sat ? 16'h7FFF : 16'(a + 1);
      wait_neg(1);
    end
    c_addr = 8'd200;  // outside the RAM: must be ignored
    c_in   = 16'h1234;
    wait_neg(1);
  endtask

  // Starts a frame with sample d and leaves the bench mid-window of output slot 0.
  task automatic start_frame(input logic [15:0] d, input logic [2:0] dv, input bit keep);
    nrst = 1'b1;
    c_we = 1'b0;
    din  = d;
    div  = dv;
    wait_neg(1);
    if (!keep) din = 16'h0000;
    wait_neg(D + D / 2 - 1);
  endtask

  // Impulse of -32768 with div=2 gives -h[k] in slot k, then zeros.
  task automatic impulse_run(input int nslots);
    int h;
    for (int k = 0; k < nslots; k++) begin
      h = (k < HALF) ? k + 1 : ((k < 2 * HALF) ? 2 * HALF - k : 0);
      check($sformatf("impulse k=%0d", k), dout, 16'(-h));
      wait_neg(D);
    end
  endtask

  initial begin
    nrst = 1'b0; c_we = 1'b0; din = 16'h0000; div = 3'd0; c_in = 16'h0000; c_addr = 8'd0;
    wait_neg(2);
    chk_en = 1'b1;
    check("reset dout", dout, 16'h0000);

    nrst = 1'b1;
    load_coeffs(1'b0);
    start_frame(16'h8000, 3'd2, 1'b0);
    impulse_run(2 * HALF + 40 * M);

    // Freeze mid-frame, then a div=3 impulse; div changes mid-slot 4
    c_we = 1'b1; c_addr = 8'd200; c_in = 16'h1234;
    wait_neg(5);
    start_frame(16'h8000, 3'd3, 1'b0);
    check("div3 k0", dout, 16'h0000); wait_neg(D);
    check("div3 k1", dout, 16'hFFFF); wait_neg(D);
    check("div3 k2", dout, 16'hFFFF); wait_neg(D);
    check("div3 k3", dout, 16'hFFFE);
    div = 3'd2;
    wait_neg(D);
    check("div2 k4", dout, 16'hFFFB); wait_neg(D);
    check("div2 k5", dout, 16'hFFFA);

    nrst = 1'b0;
    wait_neg(1);
    check("reset mid-slot", dout, 16'h0000);
    start_frame(16'h8000, 3'd2, 1'b0);
    impulse_run(2 * HALF + 2);

    nrst = 1'b0;
    wait_neg(2);
    nrst = 1'b1;
    load_coeffs(1'b1);
    start_frame(16'h7FFF, 3'd0, 1'b1);
    check("sat pos k0", dout, 16'h7FFF); wait_neg(D);
    check("sat pos k1", dout, 16'h7FFF);

    nrst = 1'b0;
    wait_neg(2);
    check("reset before neg", dout, 16'h0000);
    start_frame(16'h8000, 3'd0, 1'b1);
    check("sat neg k0", dout, 16'h8000); wait_neg(D);
    check("sat neg k1", dout, 16'h8000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
